// File: rtl/dm_access_unit_if.sv
// Core-side request/response bundle plus the word-only data-memory port.
// The unit takes the slave view; the core/memory environment takes the master view.
interface dm_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       pc;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              misalign;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_we;
  logic [31:0]       dm_pc;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, pc, dm_rdata,
    output busy, done, rdata, misalign, dm_addr, dm_wdata, dm_we, dm_pc
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, pc, dm_rdata,
    input  busy, done, rdata, misalign, dm_addr, dm_wdata, dm_we, dm_pc
  );
endinterface

// File: rtl/dm_access_unit.sv
// Multi-cycle byte/half/word load-store initiator in front of a word-only data memory.
// Sub-word stores are done as read-modify-write of the containing word.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   IDLE   | waiting for req; DM port quiet
//   RD     | load: extract/extend the addressed lanes into rdata
//   RMW_RD | sub-word store: merge new lanes into the read word
//   WR     | drive dm_we with the merged word for one cycle
//   RESP   | done pulse (with misalign if the request was rejected)
module dm_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  dm_access_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              sign_ext_q;
  logic [31:0]       pc_q;
  logic              misalign_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;

  logic              illegal;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_val;
  logic [31:0]       merge_next;

  always_comb begin
    illegal = (bus.size == 2'b11) ||
              ((bus.size == 2'b01) && bus.addr[0]) ||
              ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
  end

  always_comb begin
    load_byte = bus.dm_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    load_byte = bus.dm_rdata[7:0];
      2'd1:    load_byte = bus.dm_rdata[15:8];
      2'd2:    load_byte = bus.dm_rdata[23:16];
      default: load_byte = bus.dm_rdata[31:24];
    endcase
    load_half = addr_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & load_byte[7]}}, load_byte};
      2'b01:   load_val = {{16{sign_ext_q & load_half[15]}}, load_half};
      default: load_val = bus.dm_rdata;
    endcase
  end

  // Replace only the target lane(s) of the word just read back.
  always_comb begin
    merge_next = bus.dm_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_next[7:0]   = wdata_q[7:0];
        2'd1:    merge_next[15:8]  = wdata_q[7:0];
        2'd2:    merge_next[23:16] = wdata_q[7:0];
        default: merge_next[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_next[31:16] = wdata_q[15:0];
    end else begin
      merge_next[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      pc_q       <= '0;
      misalign_q <= 1'b0;
      merge_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            size_q     <= bus.size;
            we_q       <= bus.we;
            sign_ext_q <= bus.sign_ext;
            pc_q       <= bus.pc;
            misalign_q <= illegal;
            if (illegal) begin
              state <= S_RESP;
            end else if (!bus.we) begin
              state <= S_RD;
            end else if (bus.size == 2'b10) begin
              merge_q <= bus.wdata;
              state   <= S_WR;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_RD: begin
          rdata_q <= load_val;
          state   <= S_RESP;
        end
        S_RMW_RD: begin
          merge_q <= merge_next;
          state   <= S_WR;
        end
        S_WR:    state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_RESP);
  assign bus.misalign = (state == S_RESP) && misalign_q;
  assign bus.rdata    = rdata_q;
  assign bus.dm_addr  = (state != S_IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.dm_we    = (state == S_WR);
  assign bus.dm_wdata = (state == S_WR) ? merge_q : 32'd0;
  assign bus.dm_pc    = pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed + random bench for dm_access_unit with a word-array DM model
// and a lane-arithmetic reference model of loads and stores.
module tb_dm_access_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   we_cnt;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rdata;

  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  dm_access_unit_if #(.ADDR_W(32)) bus ();

  dm_access_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.dm_we) begin
      mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_ref(logic [31:0] word, logic [1:0] sz, logic sx, logic [31:0] a);
    logic [31:0] v;
    int nbits;
    if (sz == 2'd2) return word;
    nbits = (sz == 2'd0) ? 8 : 16;
    if (sz == 2'd0) v = (word >> (8 * a[1:0])) & 32'hFF;
    else            v = (word >> (16 * a[1])) & 32'hFFFF;
    if (sx && v[nbits-1]) v = v | (32'hFFFF_FFFF << nbits);
    return v;
  endfunction

  function automatic logic [31:0] store_ref(logic [31:0] old, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    int sh;
    logic [31:0] mask;
    if (sz == 2'd2) return d;
    sh   = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] d);
    logic        ill;
    int          lat;
    int          cyc;
    int          wc0;
    int          idx;
    logic [31:0] pcv;
    ill = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    lat = ill ? 0 : ((!w || sz == 2'd2) ? 1 : 2);
    idx = int'(a[7:2]);
    pcv = $urandom;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d; bus.pc = pcv;
    wc0 = we_cnt;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check({tag, ":busy_e0"}, {31'd0, bus.busy}, 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 8) begin
      if (bus.dm_we) check({tag, ":dm_addr"}, bus.dm_addr, {a[31:2], 2'b00});
      @(posedge clk); #1;
      cyc++;
    end
    if (!ill) begin
      if (!w) exp_rdata = load_ref(ref_mem[idx], sz, sx, a);
      else    ref_mem[idx] = store_ref(ref_mem[idx], sz, a, d);
    end
    check({tag, ":latency"}, cyc, lat);
    check({tag, ":done"}, {31'd0, bus.done}, 32'd1);
    check({tag, ":misalign"}, {31'd0, bus.misalign}, {31'd0, ill});
    check({tag, ":rdata"}, bus.rdata, exp_rdata);
    check({tag, ":dm_pc"}, bus.dm_pc, pcv);
    check({tag, ":writes"}, we_cnt - wc0, (w && !ill) ? 1 : 0);
    check({tag, ":mem"}, mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
    check({tag, ":idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] bpat;
    logic [7:0] dpat;
    int         wc0;
    logic [1:0] rsz;

    checks = 0; errors = 0; we_cnt = 0;
    reset = 1'b0;
    pre_en = 1'b1; pre_idx = '0; pre_val = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.pc = '0;
    exp_rdata = 32'd0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_idx = i[5:0];
      pre_val = $urandom;
      ref_mem[i] = pre_val;
    end
    @(negedge clk);
    pre_en = 1'b0;

    check("rst:busy", {31'd0, bus.busy}, 32'd0);
    check("rst:done", {31'd0, bus.done}, 32'd0);
    check("rst:misalign", {31'd0, bus.misalign}, 32'd0);
    check("rst:dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("rst:dm_addr", bus.dm_addr, 32'd0);
    check("rst:dm_wdata", bus.dm_wdata, 32'd0);
    check("rst:dm_pc", bus.dm_pc, 32'd0);
    check("rst:rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    op("sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    check("sw:word", mem[4], 32'h12345678);
    op("lb_s13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check("lb_s13:val", bus.rdata, 32'h00000012);
    op("lbu10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    check("lbu10:val", bus.rdata, 32'h00000078);
    op("lhu12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("lhu12:val", bus.rdata, 32'h00001234);

    op("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    check("sb11:word", mem[4], 32'h1234AB78);
    op("lb_s11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    check("lb_s11:val", bus.rdata, 32'hFFFFFFAB);
    op("lbu11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    check("lbu11:val", bus.rdata, 32'h000000AB);

    op("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
    check("sh12:word", mem[4], 32'hBEEFAB78);
    op("lh_s12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("lh_s12:val", bus.rdata, 32'hFFFFBEEF);
    op("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw10:val", bus.rdata, 32'hBEEFAB78);

    op("bad_lw12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    op("bad_sh11", 1'b1, 2'd1, 1'b0, 32'h11, 32'h00001111);
    op("bad_sz3", 1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF);
    check("bad:word", mem[4], 32'hBEEFAB78);
    check("bad:rdata", bus.rdata, 32'hBEEFAB78);

    // req held high: a new transaction starts only from each IDLE cycle
    bpat = 8'h77;
    dpat = 8'h44;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 32'h22; bus.wdata = 32'h000000C3; bus.pc = 32'h400;
    wc0 = we_cnt;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold:busy%0d", k), {31'd0, bus.busy}, {31'd0, bpat[k]});
      check($sformatf("hold:done%0d", k), {31'd0, bus.done}, {31'd0, dpat[k]});
    end
    @(negedge clk);
    bus.req = 1'b0;
    ref_mem[8] = store_ref(ref_mem[8], 2'd0, 32'h22, 32'h000000C3);
    check("hold:writes", we_cnt - wc0, 2);
    check("hold:mem", mem[8], ref_mem[8]);
    @(posedge clk); #1;
    check("hold:idle", {31'd0, bus.busy}, 32'd0);

    // asynchronous reset in the middle of the RMW_RD cycle
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'h00000055; bus.pc = 32'h800;
    wc0 = we_cnt;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("arst:busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst:busy", {31'd0, bus.busy}, 32'd0);
    check("arst:done", {31'd0, bus.done}, 32'd0);
    check("arst:dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("arst:dm_addr", bus.dm_addr, 32'd0);
    check("arst:dm_wdata", bus.dm_wdata, 32'd0);
    check("arst:dm_pc", bus.dm_pc, 32'd0);
    check("arst:rdata", bus.rdata, 32'd0);
    exp_rdata = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("arst:writes", we_cnt - wc0, 0);
    check("arst:mem", mem[4], 32'hBEEFAB78);
    @(negedge clk);
    reset = 1'b1;
    op("arst_lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("arst_lw10:val", bus.rdata, 32'hBEEFAB78);

    for (int n = 0; n < 60; n++) begin
      rsz = 2'($urandom_range(0, 3));
      op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 255)), $urandom);
    end

    for (int i = 0; i < 64; i++) begin
      check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
